// File: rtl/ram_arb_ctrl.sv
// Round-robin arbiter and sequencer that serialises two requesters onto one single-port RAM.
// Each access runs IDLE -> ISSUE -> CAPTURE -> RESP; out-of-range addresses go straight to RESP.
module ram_arb_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 16000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_err0,
    output logic              o_err1,
    output logic              o_busy,
    output logic              o_ram_en,
    output logic              o_ram_rw,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    input  logic              i_ram_read_ack,
    input  logic              i_ram_write_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(RAM_DEPTH);

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic                r_ram_en;
    logic                r_ram_rw;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_done0;
    logic                r_done1;
    logic                r_err0;
    logic                r_err1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_any;
    logic                w_grant1;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_oor;
    logic                w_ack_ok;
    logic [DATA_W-1:0]   w_cap_rdata;

    // r_last is the port served most recently; on a tie the other port wins.
    assign w_any       = i_req0 | i_req1;
    assign w_grant1    = i_req1 & (~i_req0 | ~r_last);
    assign w_we        = w_grant1 ? i_we1    : i_we0;
    assign w_addr      = w_grant1 ? i_addr1  : i_addr0;
    assign w_wdata     = w_grant1 ? i_wdata1 : i_wdata0;
    assign w_oor       = {1'b0, w_addr} >= DEPTH_LIM;

    // RAM acks are sticky levels, so only the pair seen in CAPTURE matters.
    assign w_ack_ok    = r_we ? (i_ram_write_ack & ~i_ram_read_ack)
                              : (i_ram_read_ack  & ~i_ram_write_ack);
    assign w_cap_rdata = r_we ? '0 : i_ram_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_rw    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_ram_en <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant1;
                        r_we    <= w_we;
                        if (w_oor) begin
                            r_state <= RESP;
                            if (w_grant1) begin
                                r_done1 <= 1'b1;
                                r_err1  <= 1'b1;
                            end else begin
                                r_done0 <= 1'b1;
                                r_err0  <= 1'b1;
                            end
                        end else begin
                            r_state     <= ISSUE;
                            r_ram_en    <= 1'b1;
                            r_ram_rw    <= w_we;
                            r_ram_addr  <= w_addr;
                            r_ram_wdata <= w_wdata;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_state <= RESP;
                    if (r_owner) begin
                        r_done1  <= 1'b1;
                        r_rdata1 <= w_cap_rdata;
                        r_err1   <= ~w_ack_ok;
                    end else begin
                        r_done0  <= 1'b1;
                        r_rdata0 <= w_cap_rdata;
                        r_err0   <= ~w_ack_ok;
                    end
                end
                RESP: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_ram_en    = r_ram_en;
    assign o_ram_rw    = r_ram_rw;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_err0      = r_err0;
    assign o_err1      = r_err1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl with a behavioural sticky-ack RAM and a scoreboard queue
// holding the expected completion of every request.
module tb_ram_arb_ctrl;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 16000;

    typedef struct {
        bit                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                oor;
        logic [DATA_W-1:0] rdata;
        bit                err;
        int                due;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              done0, done1, err0, err1, busy;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ramEn, ramRw;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWdata;
    logic [DATA_W-1:0] ramRdata = '0;
    logic              ramRack = 1'b0;
    logic              ramWack = 1'b0;
    logic              dropWack = 1'b0;
    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    exp_t q[$];
    int   cycle = 0;
    int   enCount = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   doneFlag [2];

    ram_arb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH)) dut (
        .i_clk(clock), .i_rst(reset),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(done0), .o_done1(done1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_err0(err0), .o_err1(err1), .o_busy(busy),
        .o_ram_en(ramEn), .o_ram_rw(ramRw), .o_ram_addr(ramAddr), .o_ram_wdata(ramWdata),
        .i_ram_rdata(ramRdata), .i_ram_read_ack(ramRack), .i_ram_write_ack(ramWack)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Single-port RAM: registered read data, acks that stay at their last value.
    always @(posedge clock) begin
        if (ramEn) begin
            if (ramRw) begin
                mem[ramAddr] <= ramWdata;
                ramWack      <= ~dropWack;
                ramRack      <= 1'b0;
            end else begin
                ramRdata <= mem[ramAddr];
                ramRack  <= 1'b1;
                ramWack  <= 1'b0;
            end
        end
    end

    // Safety net in case a bounded wait is somehow bypassed.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and score everything the DUT shows there.
    task automatic stepCycle();
        exp_t e;
        logic d, er;
        logic [DATA_W-1:0] rd;
        @(negedge clock);
        cycle++;
        if (ramEn) begin
            if (q.size() == 0) begin
                checkOutput("ramEnUnexpected", 32'(ramEn), 32'd0);
            end else begin
                e = q[0];
                checkOutput("ramEnOnce", 32'(enCount), 32'd0);
                checkOutput("ramAddr", 32'(ramAddr), 32'(e.addr));
                checkOutput("ramRw", 32'(ramRw), 32'(e.we));
                if (e.we) checkOutput("ramWdata", ramWdata, e.wdata);
                enCount++;
            end
        end
        checkOutput("doneBoth", 32'(done0 & done1), 32'd0);
        for (int p = 0; p < 2; p++) begin
            d  = (p == 1) ? done1  : done0;
            er = (p == 1) ? err1   : err0;
            rd = (p == 1) ? rdata1 : rdata0;
            if (d) begin
                doneFlag[p] = 1'b1;
                if (q.size() == 0) begin
                    checkOutput("doneUnexpected", 32'(d), 32'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("donePort", 32'(p), 32'(e.port));
                    checkOutput("doneCycle", 32'(cycle), 32'(e.due));
                    checkOutput("err", 32'(er), 32'(e.err));
                    if (!e.we) checkOutput("rdata", rd, e.rdata);
                    checkOutput("busyInResp", 32'(busy), 32'd1);
                    checkOutput("ramEnCount", 32'(enCount), e.oor ? 32'd0 : 32'd1);
                    enCount = 0;
                end
            end else begin
                checkOutput("rdataQuiet", rd, 32'd0);
                checkOutput("errQuiet", 32'(er), 32'd0);
            end
        end
    endtask

    task automatic waitDone(bit p, int budget);
        doneFlag[p] = 1'b0;
        for (int i = 0; i < budget; i++) begin
            stepCycle();
            if (doneFlag[p]) break;
        end
        checkOutput("doneTimeout", 32'(doneFlag[p]), 32'd1);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    function automatic exp_t makeExp(bit p, bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd,
                                     logic [DATA_W-1:0] rd, bit er, int due);
        exp_t e;
        e.port  = p;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        e.oor   = (32'(a) >= RAM_DEPTH);
        e.rdata = e.oor ? '0 : rd;
        e.err   = e.oor ? 1'b1 : er;
        e.due   = e.oor ? due - 2 : due;
        return e;
    endfunction

    task automatic drivePort(bit p, bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
        if (p) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end
    endtask

    // One complete access from an idle DUT: drive, predict, wait for completion.
    task automatic applyStimulus(bit p, bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd,
                                 logic [DATA_W-1:0] expRd, bit expErr);
        stepCycle();
        drivePort(p, we, a, wd);
        q.push_back(makeExp(p, we, a, wd, expRd, expErr, cycle + 3));
        waitDone(p, 12);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        q.delete();
        enCount = 0;
        stepCycle();
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetRamEn", 32'(ramEn), 32'd0);
        checkOutput("resetRamAddr", 32'(ramAddr), 32'd0);
        checkOutput("resetDone", 32'({done0, done1}), 32'd0);
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        int c;
        $display("[TB] reset");
        applyReset();

        $display("[TB] port0 write then read 0x0005");
        applyStimulus(0, 1, 14'h0005, 32'hDEADBEEF, '0, 0);
        applyStimulus(0, 0, 14'h0005, '0, 32'hDEADBEEF, 0);

        $display("[TB] preload through both ports");
        applyStimulus(1, 1, 14'h0001, 32'h11, '0, 0);
        applyStimulus(1, 1, 14'h0002, 32'h22, '0, 0);
        applyStimulus(1, 1, 14'h0010, 32'hA0, '0, 0);
        applyStimulus(0, 1, 14'h0020, 32'hB0, '0, 0);
        applyStimulus(0, 1, 14'h3E7F, 32'h5A5A, '0, 0);

        $display("[TB] address range boundary");
        applyStimulus(1, 0, 14'h3E80, '0, '0, 1);
        applyStimulus(1, 1, 14'h3FFF, 32'hFFFF, '0, 1);
        applyStimulus(1, 0, 14'h3E7F, '0, 32'h5A5A, 0);

        $display("[TB] back-to-back reads with sticky read ack");
        applyStimulus(0, 0, 14'h0001, '0, 32'h11, 0);
        applyStimulus(0, 0, 14'h0002, '0, 32'h22, 0);

        $display("[TB] missing write ack");
        dropWack = 1'b1;
        applyStimulus(1, 1, 14'h0007, 32'h77, '0, 1);
        dropWack = 1'b0;
        applyStimulus(1, 1, 14'h0008, 32'h88, '0, 0);
        applyStimulus(1, 0, 14'h0007, '0, 32'h77, 0);

        $display("[TB] simultaneous requests alternate");
        applyReset();
        stepCycle();
        c = cycle;
        drivePort(0, 0, 14'h0010, '0);
        drivePort(1, 0, 14'h0020, '0);
        q.push_back(makeExp(0, 0, 14'h0010, '0, 32'hA0, 0, c + 3));
        q.push_back(makeExp(1, 0, 14'h0020, '0, 32'hB0, 0, c + 7));
        q.push_back(makeExp(0, 0, 14'h0010, '0, 32'hA0, 0, c + 11));
        q.push_back(makeExp(1, 0, 14'h0020, '0, 32'hB0, 0, c + 15));
        while (cycle < c + 15) stepCycle();
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("queueDrain", 32'(q.size()), 32'd0);
        for (int i = 0; i < 4; i++) stepCycle();

        $display("[TB] reset during capture");
        c = cycle;
        drivePort(0, 1, 14'h0009, 32'h99);
        q.push_back(makeExp(0, 1, 14'h0009, 32'h99, '0, 0, c + 3));
        stepCycle();
        stepCycle();
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortRamEn", 32'(ramEn), 32'd0);
        checkOutput("abortDone", 32'({done0, done1}), 32'd0);
        q.delete();
        enCount = 0;
        req0 = 1'b0;
        stepCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 14'h0002, '0, 32'h22, 0);
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("finalQueue", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
